// File: rtl/avg_sched.sv
// Two-channel 3-tap weighted-average scheduler sharing one multiply-accumulate unit.
// Round-robin grant, one tap product per cycle, saturated result on a valid/ready port.
module avg_sched #(
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 8,
   parameter int NTAPS     = 3,
   parameter int COEF_RST  = 2,
   parameter int OUT_SHIFT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [COEF_W-1:0] cfg_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_chan,
   input  logic              o_ready,
   output logic              busy
);

   localparam int ACC_W = DATA_W + COEF_W + 2;
   localparam logic [1:0] LAST_K = 2'(NTAPS - 1);
   localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                   state;
   logic [DATA_W-1:0]        hist0 [NTAPS];
   logic [DATA_W-1:0]        hist1 [NTAPS];
   logic [COEF_W-1:0]        coef  [NTAPS];
   logic [ACC_W-1:0]         acc;
   logic [1:0]               k;
   logic                     sel;
   logic                     last_grant;
   logic                     grant;
   logic                     accept;
   logic [DATA_W-1:0]        tap_k;
   logic [DATA_W+COEF_W-1:0] prod;
   logic [ACC_W-1:0]         acc_nxt;

   function automatic logic [DATA_W-1:0] sat_out(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0] s;
      s = a >> OUT_SHIFT;
      if (s > OUT_MAX) return '1;
      return s[DATA_W-1:0];
   endfunction

   // With both channels requesting, the one not served last wins.
   always_comb begin
      grant = ~last_grant;
      if (req0_valid && !req1_valid)      grant = 1'b0;
      else if (req1_valid && !req0_valid) grant = 1'b1;
   end

   assign req0_ready = (state == IDLE) && !grant && rst_n;
   assign req1_ready = (state == IDLE) &&  grant && rst_n;
   assign accept     = (state == IDLE) && (grant ? req1_valid : req0_valid);
   assign busy       = (state != IDLE);

   always_comb begin
      tap_k   = sel ? hist1[k] : hist0[k];
      prod    = tap_k * coef[k];
      acc_nxt = acc + ACC_W'(prod);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         for (int i = 0; i < NTAPS; i++) begin
            hist0[i] <= '0;
            hist1[i] <= '0;
            coef[i]  <= COEF_W'(COEF_RST);
         end
         acc        <= '0;
         k          <= '0;
         sel        <= 1'b0;
         last_grant <= 1'b1;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_chan     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_we && cfg_addr <= LAST_K) coef[cfg_addr] <= cfg_data;
               if (accept) begin
                  if (grant) begin
                     hist1[0] <= req1_data;
                     for (int i = 1; i < NTAPS; i++) hist1[i] <= hist1[i-1];
                  end else begin
                     hist0[0] <= req0_data;
                     for (int i = 1; i < NTAPS; i++) hist0[i] <= hist0[i-1];
                  end
                  acc   <= '0;
                  k     <= '0;
                  sel   <= grant;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc_nxt;
               k   <= k + 2'd1;
               // Result register is loaded with the final sum so OUT presents it immediately.
               if (k == LAST_K) begin
                  state   <= OUT;
                  o_valid <= 1'b1;
                  o_chan  <= sel;
                  o_data  <= sat_out(acc_nxt);
               end
            end
            OUT: begin
               if (o_ready) begin
                  o_valid    <= 1'b0;
                  last_grant <= sel;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avg_sched.sv
// Directed bench for avg_sched: latency, round-robin, saturation, backpressure,
// coefficient programming and mid-sample reset.
module tb_avg_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_data = '0;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_data = '0;
   logic       req1_ready;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_chan;
   logic       o_ready = 1'b0;
   logic       busy;

   int checks = 0;
   int errors = 0;

   avg_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .o_valid(o_valid), .o_data(o_data), .o_chan(o_chan), .o_ready(o_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic apply_reset;
      @(negedge clk);
      req0_valid = 0; req1_valid = 0; cfg_we = 0; o_ready = 1; rst_n = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   // Sends one sample and returns the result; returns at a negedge (after the transfer if o_ready).
   task automatic do_sample(input bit ch, input logic [7:0] d, output logic [7:0] od,
                            output logic oc, output int lat, output bit tmo);
      int n;
      tmo = 0;
      if (ch) begin req1_valid = 1; req1_data = d; end
      else    begin req0_valid = 1; req0_data = d; end
      #1;
      n = 0;
      while (!(ch ? req1_ready : req0_ready) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 50) tmo = 1;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      n = 1;
      while (!o_valid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) tmo = 1;
      lat = n - 1;
      od = o_data; oc = o_chan;
      if (o_ready) @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 0; req0_valid = 1; req1_valid = 1;
      @(negedge clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid got %b want 0", o_valid); end
      checks++; if (o_data !== 8'd0) begin errors++; $display("FAIL rst_o_data got %0d want 0", o_data); end
      checks++; if (o_chan !== 1'b0) begin errors++; $display("FAIL rst_o_chan got %b want 0", o_chan); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL rst_ready got %b%b want 00", req0_ready, req1_ready); end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_latency;
      logic [7:0] din [3] = '{8'd10, 8'd20, 8'd30};
      logic [7:0] exp [3] = '{8'd20, 8'd60, 8'd120};
      logic [7:0] od; logic oc; int lat; bit tmo;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         do_sample(1'b0, din[i], od, oc, lat, tmo);
         checks++; if (tmo) begin errors++; $display("FAIL t1_timeout[%0d] got timeout want result", i); end
         checks++; if (od !== exp[i]) begin errors++; $display("FAIL t1_data[%0d] got %0d want %0d", i, od, exp[i]); end
         checks++; if (oc !== 1'b0) begin errors++; $display("FAIL t1_chan[%0d] got %b want 0", i, oc); end
         checks++; if (lat != 3) begin errors++; $display("FAIL t1_latency[%0d] got %0d want 3", i, lat); end
      end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop got %b want 0", o_valid); end
   endtask

   task automatic test_round_robin;
      logic       exp_c [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_d [6] = '{8'd2, 8'd10, 8'd4, 8'd20, 8'd6, 8'd30};
      logic       got_c [6];
      logic [7:0] got_d [6];
      int cnt = 0;
      apply_reset();
      req0_valid = 1; req0_data = 8'd1; req1_valid = 1; req1_data = 8'd5; o_ready = 1;
      for (int n = 0; n < 80 && cnt < 6; n++) begin
         @(negedge clk);
         if (o_valid) begin got_c[cnt] = o_chan; got_d[cnt] = o_data; cnt++; end
      end
      req0_valid = 0; req1_valid = 0;
      checks++; if (cnt != 6) begin errors++; $display("FAIL t2_count got %0d want 6", cnt); end
      for (int i = 0; i < cnt; i++) begin
         checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL t2_chan[%0d] got %b want %b", i, got_c[i], exp_c[i]); end
         checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL t2_data[%0d] got %0d want %0d", i, got_d[i], exp_d[i]); end
      end
   endtask

   task automatic test_saturation;
      logic [7:0] od; logic oc; int lat; bit tmo;
      apply_reset();
      do_sample(1'b0, 8'd200, od, oc, lat, tmo);
      checks++; if (tmo || od !== 8'd255) begin errors++; $display("FAIL t3_sat400 got %0d want 255", od); end
      do_sample(1'b0, 8'd200, od, oc, lat, tmo);
      checks++; if (tmo || od !== 8'd255) begin errors++; $display("FAIL t3_sat800 got %0d want 255", od); end
   endtask

   task automatic test_backpressure;
      logic [7:0] od; logic oc; int lat; bit tmo; bit bad = 0; int n;
      apply_reset();
      o_ready = 0;
      do_sample(1'b0, 8'd50, od, oc, lat, tmo);
      checks++; if (tmo || od !== 8'd100) begin errors++; $display("FAIL t4_data got %0d want 100", od); end
      req1_valid = 1; req1_data = 8'd5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (o_valid !== 1'b1 || o_data !== 8'd100 || o_chan !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL t4_hold got unstable/ready want held v=1 d=100 c=0 rdy=00"); end
      o_ready = 1;
      @(negedge clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL t4_one_transfer got o_valid=%b want 0", o_valid); end
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL t4_new_ready got %b want 1", req1_ready); end
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_new_accept got busy=%b want 1", busy); end
      req1_valid = 0;
      n = 0;
      while (!o_valid && n < 20) begin @(negedge clk); n++; end
      checks++; if (o_data !== 8'd10 || o_chan !== 1'b1) begin
         errors++; $display("FAIL t4_next got d=%0d c=%b want d=10 c=1", o_data, o_chan); end
      @(negedge clk);
   endtask

   task automatic test_config;
      logic [7:0] cv [3] = '{8'd1, 8'd0, 8'd0};
      logic [7:0] od; logic oc; int lat; bit tmo; int n;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         cfg_we = 1; cfg_addr = 2'(i); cfg_data = cv[i];
         @(negedge clk);
      end
      cfg_we = 0;
      do_sample(1'b1, 8'd77, od, oc, lat, tmo);
      checks++; if (tmo || od !== 8'd77 || oc !== 1'b1) begin errors++; $display("FAIL t5_prog got d=%0d c=%b want d=77 c=1", od, oc); end
      req1_valid = 1; req1_data = 8'd4;
      @(negedge clk);
      req1_valid = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy got %b want 1", busy); end
      cfg_we = 1; cfg_addr = 2'd0; cfg_data = 8'd3;
      @(negedge clk);
      cfg_we = 0;
      n = 0;
      while (!o_valid && n < 20) begin @(negedge clk); n++; end
      checks++; if (o_data !== 8'd4) begin errors++; $display("FAIL t5_mid got %0d want 4", o_data); end
      @(negedge clk);
      cfg_we = 1; cfg_addr = 2'd3; cfg_data = 8'd5;
      @(negedge clk);
      cfg_we = 0;
      do_sample(1'b1, 8'd9, od, oc, lat, tmo);
      checks++; if (tmo || od !== 8'd9) begin errors++; $display("FAIL t5_ignored got %0d want 9", od); end
   endtask

   task automatic test_mid_reset;
      logic [7:0] od; logic oc; int lat; bit tmo; bit seen = 0;
      apply_reset();
      cfg_we = 1; cfg_addr = 2'd0; cfg_data = 8'd1;
      @(negedge clk);
      cfg_we = 0;
      req0_valid = 1; req0_data = 8'd100;
      @(negedge clk);
      req0_valid = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_in_mac got busy=%b want 1", busy); end
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy got %b want 0", busy); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (o_valid) seen = 1;
      end
      checks++; if (seen) begin errors++; $display("FAIL t6_no_output got o_valid=1 want 0"); end
      do_sample(1'b0, 8'd7, od, oc, lat, tmo);
      checks++; if (tmo || od !== 8'd14) begin errors++; $display("FAIL t6_after got %0d want 14", od); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_round_robin();
      test_saturation();
      test_backpressure();
      test_config();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
